// File: rtl/ptw_arbiter.sv
// Round-robin arbiter that shares one page table walker between NUM_REQ TLB miss sources.
// Define PTW_ARB_PERF_EN to add saturating grant/wait performance counters.
module ptw_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [32*NUM_REQ-1:0]   req_vaddr_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,
  output logic [31:0]             resp_pte_o,
  output logic                    ptw_req_valid_o,
  input  logic                    ptw_req_ready_i,
  output logic [31:0]             ptw_vaddr_o,
  input  logic                    ptw_resp_valid_i,
  output logic                    ptw_resp_ready_o,
  input  logic [31:0]             ptw_pte_i
`ifdef PTW_ARB_PERF_EN
  ,
  output logic [16*NUM_REQ-1:0]   perf_grants_o,
  output logic [15:0]             perf_wait_o
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RETURN = 2'd3;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [31:0]      vaddr_q, vaddr_d;
  logic [31:0]      pte_q, pte_d;

  logic [2*NUM_REQ-1:0] valid_rot;
  logic [IDX_W:0]       grant_sum;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   grant_q_oh;
  logic [31:0]          sel_vaddr;

  // Rotating by rr_ptr makes the first set bit the round-robin winner.
  assign valid_rot = {req_valid_i, req_valid_i} >> rr_ptr_q;

  always_comb begin
    any_valid = 1'b0;
    grant_sum = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && valid_rot[i]) begin
        any_valid = 1'b1;
        grant_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
        if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
        grant_idx = grant_sum[IDX_W-1:0];
      end
    end
  end

  assign grant_oh   = NUM_REQ'(1) << grant_idx;
  assign grant_q_oh = NUM_REQ'(1) << grant_q;

  always_comb begin
    sel_vaddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) sel_vaddr = req_vaddr_i[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    vaddr_d  = vaddr_q;
    pte_d    = pte_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = grant_idx;
          vaddr_d = sel_vaddr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ptw_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ptw_resp_valid_i) begin
          pte_d   = ptw_pte_i;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        // Only the granted requester's ready can complete the response.
        if (|(resp_ready_i & grant_q_oh)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      vaddr_q  <= '0;
      pte_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      vaddr_q  <= vaddr_d;
      pte_q    <= pte_d;
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE && any_valid) ? grant_oh : '0;
  assign ptw_req_valid_o  = (state_q == ST_ISSUE);
  assign ptw_vaddr_o      = (state_q == ST_ISSUE) ? vaddr_q : '0;
  assign ptw_resp_ready_o = (state_q == ST_WAIT);
  assign resp_valid_o     = (state_q == ST_RETURN) ? grant_q_oh : '0;
  assign resp_pte_o       = (state_q == ST_RETURN) ? pte_q : '0;

`ifdef PTW_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_grants_q, perf_grants_d;
  logic [15:0]              perf_wait_q, perf_wait_d;
  logic [NUM_REQ-1:0]       owner_mask;

  // In IDLE the would-be winner is not counted as waiting.
  assign owner_mask = (state_q == ST_IDLE) ? grant_oh : grant_q_oh;

  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_wait_d   = perf_wait_q;
    if (state_q == ST_IDLE && any_valid && perf_grants_q[grant_idx] != 16'hFFFF)
      perf_grants_d[grant_idx] = perf_grants_q[grant_idx] + 16'd1;
    if (|(req_valid_i & ~owner_mask) && perf_wait_q != 16'hFFFF)
      perf_wait_d = perf_wait_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants_q <= '0;
      perf_wait_q   <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_wait_q   <= perf_wait_d;
    end
  end

  assign perf_grants_o = perf_grants_q;
  assign perf_wait_o   = perf_wait_q;
`endif

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed table-driven bench for ptw_arbiter (NUM_REQ=2) plus hand-written
// sequences for round-robin order, backpressure and reset mid-walk.
module tb_ptw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_vaddr;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_pte;
  logic        ptw_req_valid;
  logic        ptw_req_ready;
  logic [31:0] ptw_vaddr;
  logic        ptw_resp_valid;
  logic        ptw_resp_ready;
  logic [31:0] ptw_pte;
`ifdef PTW_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [15:0] perf_wait;
`endif

  int total = 0;
  int bad   = 0;

  ptw_arbiter #(.NUM_REQ(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_vaddr_i      (req_vaddr),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_pte_o       (resp_pte),
    .ptw_req_valid_o  (ptw_req_valid),
    .ptw_req_ready_i  (ptw_req_ready),
    .ptw_vaddr_o      (ptw_vaddr),
    .ptw_resp_valid_i (ptw_resp_valid),
    .ptw_resp_ready_o (ptw_resp_ready),
    .ptw_pte_i        (ptw_pte)
`ifdef PTW_ARB_PERF_EN
    ,
    .perf_grants_o    (perf_grants),
    .perf_wait_o      (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] va0;
    logic [31:0] va1;
    logic [1:0]  resp_rdy;
    logic        preq_rdy;
    logic        presp_v;
    logic [31:0] pte;
    logic [1:0]  e_req_rdy;
    logic [1:0]  e_resp_v;
    logic [31:0] e_pte;
    logic        e_preq_v;
    logic [31:0] e_vaddr;
    logic        e_presp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [31:0] a0, a1,
                              input logic [1:0] rr, input logic prr, prv, input logic [31:0] p,
                              input logic [1:0] erq, erv, input logic [31:0] ep,
                              input logic epv, input logic [31:0] eva, input logic eprr);
    vec_t t;
    t.rst = r; t.valid = v; t.va0 = a0; t.va1 = a1; t.resp_rdy = rr;
    t.preq_rdy = prr; t.presp_v = prv; t.pte = p;
    t.e_req_rdy = erq; t.e_resp_v = erv; t.e_pte = ep;
    t.e_preq_v = epv; t.e_vaddr = eva; t.e_presp_rdy = eprr;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [31:0] a0, a1,
                               input logic [1:0] rr, input logic prr, prv, input logic [31:0] p);
    @(negedge clk);
    rst            = r;
    req_valid      = v;
    req_vaddr      = {a1, a0};
    resp_ready     = rr;
    ptw_req_ready  = prr;
    ptw_resp_valid = prv;
    ptw_pte        = p;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[17];
    int   n;
    int   last;
    int   g[4];
    int   gc[4];

    rst = 1'b1; req_valid = '0; req_vaddr = '0; resp_ready = '0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_pte = '0;

    // rst, valid, va0, va1, resp_rdy, preq_rdy, presp_v, pte | req_rdy, resp_v, pte, preq_v, vaddr, presp_rdy
    vecs[0]  = mk(1, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[1]  = mk(0, 2'b10, 32'h0, 32'h0040_3000, 2'b00, 0, 0, 32'h0,   2'b10, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[2]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b00, 32'h0, 1, 32'h0040_3000, 0);
    vecs[3]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 1, 0, 32'h0,           2'b00, 2'b00, 32'h0, 1, 32'h0040_3000, 0);
    vecs[4]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b00, 32'h0, 0, 32'h0, 1);
    vecs[5]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 1, 32'h0000_5C01,   2'b00, 2'b00, 32'h0, 0, 32'h0, 1);
    vecs[6]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b10, 32'h0000_5C01, 0, 32'h0, 0);
    vecs[7]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b01, 0, 0, 32'h0,           2'b00, 2'b10, 32'h0000_5C01, 0, 32'h0, 0);
    vecs[8]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b10, 0, 0, 32'h0,           2'b00, 2'b10, 32'h0000_5C01, 0, 32'h0, 0);
    vecs[9]  = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[10] = mk(0, 2'b01, 32'h1000_0000, 32'h0, 2'b00, 0, 0, 32'h0,   2'b01, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[11] = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 1, 0, 32'h0,           2'b00, 2'b00, 32'h0, 1, 32'h1000_0000, 0);
    vecs[12] = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 1, 32'h0,           2'b00, 2'b00, 32'h0, 0, 32'h0, 1);
    vecs[13] = mk(0, 2'b00, 32'h0, 32'h0, 2'b01, 0, 0, 32'h0,           2'b00, 2'b01, 32'h0, 0, 32'h0, 0);
    vecs[14] = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 1, 32'hDEAD_BEEF,   2'b00, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[15] = mk(0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0,           2'b00, 2'b00, 32'h0, 0, 32'h0, 0);
    vecs[16] = mk(0, 2'b11, 32'hA, 32'hB, 2'b00, 0, 0, 32'h0,           2'b10, 2'b00, 32'h0, 0, 32'h0, 0);

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].va0, vecs[i].va1, vecs[i].resp_rdy,
                    vecs[i].preq_rdy, vecs[i].presp_v, vecs[i].pte);
      checkOutput($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_req_rdy));
      checkOutput($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_resp_v));
      checkOutput($sformatf("v%0d_ptw_req_valid", i), 32'(ptw_req_valid), 32'(vecs[i].e_preq_v));
      checkOutput($sformatf("v%0d_ptw_resp_ready", i), 32'(ptw_resp_ready), 32'(vecs[i].e_presp_rdy));
      if (vecs[i].e_preq_v) checkOutput($sformatf("v%0d_ptw_vaddr", i), ptw_vaddr, vecs[i].e_vaddr);
      if (vecs[i].e_resp_v != 2'b00) checkOutput($sformatf("v%0d_resp_pte", i), resp_pte, vecs[i].e_pte);
    end

    // Round-robin with both requesters always valid and walker/TLB always ready.
    doReset();
    n = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      applyStimulus(1'b0, 2'b11, 32'h0000_1000, 32'h0000_2000, 2'b11, 1'b1, 1'b1, 32'h0000_0F01);
      if (resp_valid != 2'b00) begin
        checkOutput("rr_resp_route", 32'(resp_valid), (last == 1) ? 32'h2 : 32'h1);
        checkOutput("rr_resp_pte", resp_pte, 32'h0000_0F01);
      end
      if (ptw_req_valid) checkOutput("rr_vaddr", ptw_vaddr, (last == 1) ? 32'h0000_2000 : 32'h0000_1000);
      if (req_ready != 2'b00) begin
        checkOutput("rr_onehot", 32'($countones(req_ready)), 32'd1);
        g[n]  = req_ready[1] ? 1 : 0;
        gc[n] = c;
        last  = g[n];
        n++;
      end
    end
    checkOutput("rr_grant_count", n, 4);
    for (int i = 0; i < n; i++) checkOutput($sformatf("rr_order%0d", i), g[i], i % 2);
    for (int i = 1; i < n; i++) checkOutput($sformatf("rr_gap%0d", i), gc[i] - gc[i-1], 4);

    // Backpressure: walker request stalled 5 cycles, TLB response stalled 3 cycles.
    doReset();
    applyStimulus(1'b0, 2'b01, 32'hABCD_0000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_accept", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("bp_hold_valid%0d", k), 32'(ptw_req_valid), 32'h1);
      checkOutput($sformatf("bp_hold_vaddr%0d", k), ptw_vaddr, 32'hABCD_0000);
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_issue_vaddr", ptw_vaddr, 32'hABCD_0000);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0ABC_0C0F);
    checkOutput("bp_wait_ready", 32'(ptw_resp_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF);
      checkOutput($sformatf("bp_resp_valid%0d", k), 32'(resp_valid), 32'h1);
      checkOutput($sformatf("bp_resp_pte%0d", k), resp_pte, 32'h0ABC_0C0F);
      checkOutput($sformatf("bp_ptw_resp_ready%0d", k), 32'(ptw_resp_ready), 32'h0);
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_resp_final", resp_pte, 32'h0ABC_0C0F);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_idle_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("bp_idle_ptw_req_valid", 32'(ptw_req_valid), 32'h0);

    // Reset while waiting on the walker; the late response must be dropped.
    doReset();
    applyStimulus(1'b0, 2'b10, 32'h0, 32'h5555_0000, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_accept", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_issue", 32'(ptw_req_valid), 32'h1);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_in_wait", 32'(ptw_resp_ready), 32'h1);
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b1, 32'h7777_0001);
    checkOutput("rw_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rw_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rw_resp_pte", resp_pte, 32'h0);
    checkOutput("rw_ptw_req_valid", 32'(ptw_req_valid), 32'h0);
    checkOutput("rw_ptw_vaddr", ptw_vaddr, 32'h0);
    checkOutput("rw_ptw_resp_ready", 32'(ptw_resp_ready), 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_late_resp_valid", 32'(resp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
